// File: rtl/sample_packer_pkg.sv
// sample_packer_pkg: shared helpers and the pipeline stage record for the
// sample packer.
//   clog2    - ceiling log2, used for elaboration-time widths
//   popcount - number of set bits in a channel mask
//   stage_t  - one compaction-stage record {valid, data, per-bit shift}.
//              Sized for the largest supported DW. Bits above DW are held
//              at zero with zero shift, so they never move.
package sample_packer_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_DL = 6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int popcount(input logic [MAX_DW-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DW; i++)
      if (v[i]) n++;
    return n;
  endfunction

  typedef struct packed {
    logic                           valid;
    logic [MAX_DW-1:0]              data;
    logic [MAX_DW-1:0][MAX_DL-1:0]  shift;
  } stage_t;

endpackage

// File: rtl/sample_packer_layer.sv
// sample_packer_layer: one registered layer of the compaction network.
// Each bit whose carried shift has bit L set moves down by 2^L; every other
// bit stays in place. The shift travels with its data bit. Shift amounts are
// ordered, so no two live bits ever land on the same position and OR-merging
// is safe.
//   clk, rst      - clock, async active-high reset
//   ena           - 0 freezes the stage register
//   in_s/in_ready - upstream record and ready
//   out_s/out_ready - registered record and downstream ready
module sample_packer_layer
  import sample_packer_pkg::*;
#(
  parameter int L = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  stage_t in_s,
  output logic   in_ready,
  output stage_t out_s,
  input  logic   out_ready
);

  localparam int D = 1 << L;

  stage_t nxt;

  always_comb begin
    nxt       = '0;
    nxt.valid = in_s.valid;
    for (int d = 0; d < MAX_DW; d++) begin
      if (!in_s.shift[d][L]) begin
        nxt.data[d]  = in_s.data[d];
        nxt.shift[d] = in_s.shift[d];
      end
    end
    for (int s = D; s < MAX_DW; s++) begin
      if (in_s.shift[s][L]) begin
        nxt.data[s-D]  = nxt.data[s-D] | in_s.data[s];
        nxt.shift[s-D] = nxt.shift[s-D] | in_s.shift[s];
      end
    end
  end

  // A slot is free when empty, or when its occupant leaves this cycle.
  assign in_ready = ~out_s.valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  out_s <= '0;
    else if (ena && in_ready) out_s <= nxt;
  end

endmodule

// File: rtl/sample_packer.sv
// sample_packer: compacts the channels selected by cfg_mask into the LSBs
// through a DL-layer pipelined network, then packs the compacted samples
// into dense DW-bit output words.
//   clk, rst            - clock, async active-high reset
//   ctl_clr             - flush a partially filled word (pulse)
//   ctl_ena             - 0 = combinational bypass, internal state held
//   cfg_mask            - channel select, changed only while ctl_ena=0
//   sti_valid/ready/data - input sample stream
//   sto_valid/ready/data - packed output word stream
//   sto_last            - (SAMPLE_PACKER_LAST_EN only) flags the flush word
// Optional feature macro: SAMPLE_PACKER_LAST_EN.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_clr,
  input  logic          ctl_ena,
  input  logic [DW-1:0] cfg_mask,
  input  logic          sti_valid,
  output logic          sti_ready,
  input  logic [DW-1:0] sti_data,
  output logic          sto_valid,
  input  logic          sto_ready,
`ifdef SAMPLE_PACKER_LAST_EN
  output logic          sto_last,
`endif
  output logic [DW-1:0] sto_data
);

  localparam int DL = clog2(DW);
  localparam int CW = clog2(DW + 1);

  // ---------------- config registers (tracked while bypassed) ----------------
  logic [CW-1:0]                 n_r;
  logic [MAX_DW-1:0][MAX_DL-1:0] sh_r, sh_nxt;

  // Shift for a selected bit = number of unselected bits below it.
  // Unselected bits get shift 0 so they never collide with live bits.
  always_comb begin : shift_tab
    int z;
    sh_nxt = '0;
    z      = 0;
    for (int b = 0; b < DW; b++) begin
      if (cfg_mask[b]) sh_nxt[b] = MAX_DL'(z);
      else             z++;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r  <= '0;
      sh_r <= '0;
    end else if (!ctl_ena) begin
      n_r  <= CW'(popcount(MAX_DW'(cfg_mask)));
      sh_r <= sh_nxt;
    end
  end

  // ---------------- compaction pipeline ----------------
  logic          flush_pend;
  stage_t        st_in;
  stage_t        st_q [DL];
  logic [DL:0]   rdy;
  logic [DL-1:0] vld_pipe;

  always_comb begin
    st_in       = '0;
    st_in.valid = sti_valid & ~flush_pend;
    st_in.data  = MAX_DW'(sti_data & cfg_mask);
    st_in.shift = sh_r;
  end

  for (genvar l = 0; l < DL; l++) begin : g_layer
    stage_t lin;
    if (l == 0) begin : g_first
      assign lin = st_in;
    end else begin : g_rest
      assign lin = st_q[l-1];
    end
    sample_packer_layer #(.L(l)) u_layer (
      .clk      (clk),
      .rst      (rst),
      .ena      (ctl_ena),
      .in_s     (lin),
      .in_ready (rdy[l]),
      .out_s    (st_q[l]),
      .out_ready(rdy[l+1])
    );
    assign vld_pipe[l] = st_q[l].valid;
  end

  // ---------------- packer ----------------
  stage_t          st_o;
  logic [DW-1:0]   c;
  logic [2*DW-1:0] acc, sum;
  logic [CW-1:0]   fill;
  logic [CW:0]     nfill;
  logic            emit, out_free, take, flush_go;
  logic            sto_valid_r, last_r;
  logic [DW-1:0]   sto_data_r;
  logic            unused_tail;

  assign st_o        = st_q[DL-1];
  assign c           = st_o.data[DW-1:0];
  assign unused_tail = ^{st_o.data, st_o.shift};

  assign sum      = acc | ({{DW{1'b0}}, c} << fill);
  assign nfill    = {1'b0, fill} + {1'b0, n_r};
  assign emit     = (nfill >= (CW+1)'(DW));
  assign out_free = ~sto_valid_r | sto_ready;
  // Stall the last stage only when this sample would complete a word and the
  // output register is still holding an untaken one.
  assign rdy[DL]  = ~emit | out_free;
  assign take     = ctl_ena & st_o.valid & rdy[DL];
  assign flush_go = ctl_ena & flush_pend & ~|vld_pipe & out_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      fill        <= '0;
      flush_pend  <= 1'b0;
      sto_valid_r <= 1'b0;
      sto_data_r  <= '0;
      last_r      <= 1'b0;
    end else if (ctl_ena) begin
      if (sto_ready) begin
        sto_valid_r <= 1'b0;
        last_r      <= 1'b0;
      end
      if (take) begin
        if (emit) begin
          sto_valid_r <= 1'b1;
          sto_data_r  <= sum[DW-1:0];
          last_r      <= flush_pend;
          acc         <= sum >> DW;
          fill        <= CW'(nfill - (CW+1)'(DW));
        end else begin
          acc  <= sum;
          fill <= nfill[CW-1:0];
        end
      end else if (flush_go) begin
        // Upper bits of acc are already zero above fill.
        if (fill != '0) begin
          sto_valid_r <= 1'b1;
          sto_data_r  <= acc[DW-1:0];
          last_r      <= 1'b1;
        end
        acc  <= '0;
        fill <= '0;
      end
      // A clear arriving while one is pending folds into it.
      flush_pend <= (flush_pend | ctl_clr) & ~flush_go;
    end
  end

  assign sti_ready = ctl_ena ? (rdy[0] & ~flush_pend) : sto_ready;
  assign sto_valid = ctl_ena ? sto_valid_r : sti_valid;
  assign sto_data  = ctl_ena ? sto_data_r  : sti_data;
`ifdef SAMPLE_PACKER_LAST_EN
  assign sto_last  = ctl_ena & last_r;
`else
  logic unused_last;
  assign unused_last = last_r;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed self-checking bench for sample_packer at DW=8.
module tb_sample_packer;

  logic       clk = 1'b0;
  logic       rst, ctl_clr, ctl_ena;
  logic [7:0] cfg_mask, sti_data;
  logic       sti_valid, sti_ready, sto_valid, sto_ready;
  logic [7:0] sto_data;
`ifdef SAMPLE_PACKER_LAST_EN
  logic       sto_last;
`endif

  sample_packer #(.DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctl_clr  (ctl_clr),
    .ctl_ena  (ctl_ena),
    .cfg_mask (cfg_mask),
    .sti_valid(sti_valid),
    .sti_ready(sti_ready),
    .sti_data (sti_data),
    .sto_valid(sto_valid),
    .sto_ready(sto_ready),
`ifdef SAMPLE_PACKER_LAST_EN
    .sto_last (sto_last),
`endif
    .sto_data (sto_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output word monitor.
  logic [7:0] oq_data[$];
  logic       oq_last[$];
  int         oq_cyc[$];
  always @(negedge clk) begin
    if (!rst && ctl_ena && sto_valid && sto_ready) begin
      oq_data.push_back(sto_data);
      oq_cyc.push_back(cyc);
`ifdef SAMPLE_PACKER_LAST_EN
      oq_last.push_back(sto_last);
`else
      oq_last.push_back(1'b0);
`endif
    end
  end

  // Output stability while stalled.
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data;
  int         stab_err = 0;
  always @(negedge clk) begin
    if (stall_prev && !rst && (!sto_valid || sto_data !== stall_data)) stab_err++;
    stall_prev = ctl_ena && sto_valid && !sto_ready && !rst;
    stall_data = sto_data;
  end

  task automatic clear_q();
    oq_data.delete(); oq_last.delete(); oq_cyc.delete();
  endtask

  task automatic wait_words(input int n, input int maxc);
    for (int t = 0; t < maxc && oq_data.size() < n; t++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, output int acc_cyc);
    int t;
    t = 0;
    sti_data  = d;
    sti_valid = 1'b1;
    @(negedge clk);
    while (!sti_ready && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin n_chk++; $display("FAIL send_timeout: sti_ready stuck 0 for data %h", d); end
    acc_cyc = cyc;
    @(posedge clk); #1;
    sti_valid = 1'b0;
  endtask

  task automatic set_mask(input logic [7:0] m);
    @(posedge clk); #1;
    ctl_ena  = 1'b0;
    cfg_mask = m;
    repeat (2) @(posedge clk);
    #1 ctl_ena = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 ctl_clr = 1'b1;
    @(posedge clk); #1 ctl_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ctl_clr = 1'b0; ctl_ena = 1'b1; cfg_mask = '0;
    sti_valid = 1'b0; sti_data = '0; sto_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (sto_valid !== 1'b0) $display("FAIL reset_sto_valid: got %b want 0", sto_valid); else n_pass++;
    n_chk++; if (sto_data !== 8'h00) $display("FAIL reset_sto_data: got %h want 00", sto_data); else n_pass++;
    n_chk++; if (sti_ready !== 1'b1) $display("FAIL reset_sti_ready: got %b want 1", sti_ready); else n_pass++;
`ifdef SAMPLE_PACKER_LAST_EN
    n_chk++; if (sto_last !== 1'b0) $display("FAIL reset_sto_last: got %b want 0", sto_last); else n_pass++;
`endif
    @(posedge clk); #1;
    rst = 1'b0; ctl_ena = 1'b0; sto_ready = 1'b1;
  endtask

  task automatic test_full_mask();
    int ic[3];
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
    set_mask(8'hFF);
    clear_q();
    for (int i = 0; i < 3; i++) send(exp_d[i], ic[i]);
    wait_words(3, 40);
    n_chk++; if (oq_data.size() != 3) $display("FAIL full_count: got %0d want 3", oq_data.size()); else n_pass++;
    for (int i = 0; i < 3 && i < oq_data.size(); i++) begin
      n_chk++; if (oq_data[i] !== exp_d[i]) $display("FAIL full_data%0d: got %h want %h", i, oq_data[i], exp_d[i]); else n_pass++;
      n_chk++; if (oq_cyc[i] - ic[i] != 4) $display("FAIL full_latency%0d: got %0d want 4", i, oq_cyc[i] - ic[i]); else n_pass++;
    end
  endtask

  task automatic test_nibble();
    int d;
    set_mask(8'h0F);
    clear_q();
    send(8'hA5, d);
    send(8'h3C, d);
    wait_words(1, 40);
    n_chk++; if (oq_data.size() != 1) $display("FAIL nib_count: got %0d want 1", oq_data.size()); else n_pass++;
    if (oq_data.size() > 0) begin
      n_chk++; if (oq_data[0] !== 8'hC5) $display("FAIL nib_data: got %h want c5", oq_data[0]); else n_pass++;
    end
    pulse_clr();
    repeat (10) @(negedge clk);
    n_chk++; if (oq_data.size() != 1) $display("FAIL nib_flush_empty: got %0d words want 1", oq_data.size()); else n_pass++;
    n_chk++; if (sti_ready !== 1'b1) $display("FAIL nib_ready_after_flush: got %b want 1", sti_ready); else n_pass++;
  endtask

  task automatic test_flush_last();
    int d;
    logic [7:0] s[5];
    s[0] = 8'h80; s[1] = 8'h01; s[2] = 8'h80; s[3] = 8'h81; s[4] = 8'h00;
    set_mask(8'h81);
    clear_q();
    for (int i = 0; i < 5; i++) send(s[i], d);
    // 10,01,10,11 packed LSB-first -> 8'b11_10_01_10
    wait_words(1, 40);
    repeat (6) @(negedge clk);
    n_chk++; if (oq_data.size() != 1) $display("FAIL fl_count: got %0d want 1", oq_data.size()); else n_pass++;
    if (oq_data.size() > 0) begin
      n_chk++; if (oq_data[0] !== 8'hE6) $display("FAIL fl_word: got %h want e6", oq_data[0]); else n_pass++;
`ifdef SAMPLE_PACKER_LAST_EN
      n_chk++; if (oq_last[0] !== 1'b0) $display("FAIL fl_word_last: got %b want 0", oq_last[0]); else n_pass++;
`endif
    end
    pulse_clr();
    @(negedge clk);
    n_chk++; if (sti_ready !== 1'b0) $display("FAIL fl_ready_pend: got %b want 0", sti_ready); else n_pass++;
    wait_words(2, 20);
    n_chk++; if (oq_data.size() != 2) $display("FAIL fl_flush_count: got %0d want 2", oq_data.size()); else n_pass++;
    if (oq_data.size() > 1) begin
      n_chk++; if (oq_data[1] !== 8'h00) $display("FAIL fl_flush_word: got %h want 00", oq_data[1]); else n_pass++;
`ifdef SAMPLE_PACKER_LAST_EN
      n_chk++; if (oq_last[1] !== 1'b1) $display("FAIL fl_flush_last: got %b want 1", oq_last[1]); else n_pass++;
`endif
    end
  endtask

  task automatic test_zero_mask();
    set_mask(8'h00);
    clear_q();
    for (int i = 0; i < 10; i++) begin
      sti_valid = 1'b1;
      sti_data  = 8'(i * 37 + 5);
      @(negedge clk);
      n_chk++; if (sti_ready !== 1'b1) $display("FAIL zero_ready%0d: got %b want 1", i, sti_ready); else n_pass++;
      @(posedge clk); #1;
    end
    sti_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++; if (oq_data.size() != 0) $display("FAIL zero_no_words: got %0d want 0", oq_data.size()); else n_pass++;
    pulse_clr();
    repeat (10) @(negedge clk);
    n_chk++; if (oq_data.size() != 0) $display("FAIL zero_flush_empty: got %0d want 0", oq_data.size()); else n_pass++;
  endtask

  logic [7:0] smp[200];
  bit         rnd_done;

  task automatic test_random_stall();
    logic [7:0] exp_w;
    set_mask(8'h3C);
    for (int i = 0; i < 200; i++) smp[i] = 8'($urandom);
    clear_q();
    stab_err = 0;
    rnd_done = 1'b0;
    fork
      begin
        int d;
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(smp[i], d);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin @(posedge clk); #1 sto_ready = 1'($urandom_range(0, 1)); end
        sto_ready = 1'b1;
      end
    join
    pulse_clr();
    wait_words(100, 400);
    repeat (10) @(negedge clk);
    n_chk++; if (oq_data.size() != 100) $display("FAIL rnd_count: got %0d want 100", oq_data.size()); else n_pass++;
    for (int k = 0; k < 100 && k < oq_data.size(); k++) begin
      exp_w = {smp[2*k+1][5:2], smp[2*k][5:2]};
      n_chk++; if (oq_data[k] !== exp_w) $display("FAIL rnd_word%0d: got %h want %h", k, oq_data[k], exp_w); else n_pass++;
    end
    n_chk++; if (stab_err != 0) $display("FAIL rnd_stable: got %0d stall violations want 0", stab_err); else n_pass++;
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    ctl_ena = 1'b0; sti_valid = 1'b1; sti_data = 8'h5A; sto_ready = 1'b0;
    #1;
    n_chk++; if (sto_data !== 8'h5A) $display("FAIL byp_data0: got %h want 5a", sto_data); else n_pass++;
    n_chk++; if (sto_valid !== 1'b1) $display("FAIL byp_valid1: got %b want 1", sto_valid); else n_pass++;
    n_chk++; if (sti_ready !== 1'b0) $display("FAIL byp_ready0: got %b want 0", sti_ready); else n_pass++;
`ifdef SAMPLE_PACKER_LAST_EN
    n_chk++; if (sto_last !== 1'b0) $display("FAIL byp_last: got %b want 0", sto_last); else n_pass++;
`endif
    sto_ready = 1'b1; sti_data = 8'hC3;
    #1;
    n_chk++; if (sti_ready !== 1'b1) $display("FAIL byp_ready1: got %b want 1", sti_ready); else n_pass++;
    n_chk++; if (sto_data !== 8'hC3) $display("FAIL byp_data1: got %h want c3", sto_data); else n_pass++;
    sti_valid = 1'b0;
    #1;
    n_chk++; if (sto_valid !== 1'b0) $display("FAIL byp_valid0: got %b want 0", sto_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d;
    set_mask(8'h1F);
    clear_q();
    send(8'hFF, d);                    // fill = 5
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (sto_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", sto_valid); else n_pass++;
    set_mask(8'h1F);
    clear_q();
    send(8'h0A, d);
    send(8'h13, d);                    // 01010 | 011<<5 -> 6a
    wait_words(1, 40);
    n_chk++; if (oq_data.size() != 1) $display("FAIL rm_count: got %0d want 1", oq_data.size()); else n_pass++;
    if (oq_data.size() > 0) begin
      n_chk++; if (oq_data[0] !== 8'h6A) $display("FAIL rm_word: got %h want 6a", oq_data[0]); else n_pass++;
    end
    pulse_clr();
    wait_words(2, 20);
    n_chk++; if (oq_data.size() != 2) $display("FAIL rm_flush_count: got %0d want 2", oq_data.size()); else n_pass++;
    if (oq_data.size() > 1) begin
      n_chk++; if (oq_data[1] !== 8'h02) $display("FAIL rm_flush_word: got %h want 02", oq_data[1]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_nibble();
    test_flush_last();
    test_zero_mask();
    test_random_stall();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
